// File: rtl/usbf_sync_filter_pkg.sv
// Shared constants and helpers for the multi-channel synchronizer / debounce filter.
package usbf_sync_filter_pkg;

    localparam int unsigned DefaultStage = 2;
    localparam int unsigned DefaultFilt  = 4;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/usbf_sync_filter_ch.sv
// One channel: STAGE-deep synchronizer, bypassable debounce counter, registered edge pulses.
module usbf_sync_filter_ch
    import usbf_sync_filter_pkg::*;
#(
    parameter int unsigned STAGE   = DefaultStage,
    parameter int unsigned FILT    = DefaultFilt,
    parameter bit          RST_VAL = 1'b0
) (
    input  logic clk_d,
    input  logic rst,
    input  logic din_i,
    input  logic filt_en_i,
    output logic dout_o,
    output logic rise_o,
    output logic fall_o,
    output logic chg_nxt_o
);

    localparam int unsigned CW = clog2(FILT) + 1;
    localparam logic [CW-1:0] CntMax = CW'(FILT - 1);

    logic [STAGE-1:0] sync_q, sync_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             s;

    assign s = sync_q[STAGE-1];

    always_comb begin
        sync_d = {sync_q[STAGE-2:0], din_i};
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (!filt_en_i) begin
            cnt_d  = '0;
            dout_d = s;
        end else if (s == dout_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            cnt_d  = '0;
            dout_d = s;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        rise_d = dout_d & ~dout_q;
        fall_d = ~dout_d & dout_q;
    end

    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGE{RST_VAL}};
            cnt_q  <= '0;
            dout_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dout_o    = dout_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    // Next-cycle pulse, so the top can register chg in step with rise/fall.
    assign chg_nxt_o = rise_d | fall_d;

endmodule

// File: rtl/usbf_sync_filter.sv
// Multi-channel input conditioner: DW independent sync/debounce channels plus a shared change flag.
module usbf_sync_filter
    import usbf_sync_filter_pkg::*;
#(
    parameter int unsigned    DW      = 4,
    parameter int unsigned    STAGE   = DefaultStage,
    parameter int unsigned    FILT    = DefaultFilt,
    parameter logic [DW-1:0]  RST_VAL = '0
) (
    input  logic          clk_d,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          filt_en,
    output logic [DW-1:0] dout,
    output logic [DW-1:0] rise,
    output logic [DW-1:0] fall,
    output logic          chg
);

    logic [DW-1:0] chg_nxt;
    logic          chg_q, chg_d;

    for (genvar i = 0; i < DW; i++) begin : g_ch
        usbf_sync_filter_ch #(
            .STAGE  (STAGE),
            .FILT   (FILT),
            .RST_VAL(RST_VAL[i])
        ) u_ch (
            .clk_d    (clk_d),
            .rst      (rst),
            .din_i    (din[i]),
            .filt_en_i(filt_en),
            .dout_o   (dout[i]),
            .rise_o   (rise[i]),
            .fall_o   (fall[i]),
            .chg_nxt_o(chg_nxt[i])
        );
    end

    always_comb begin
        chg_d = |chg_nxt;
    end

    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            chg_q <= 1'b0;
        end else begin
            chg_q <= chg_d;
        end
    end

    assign chg = chg_q;

endmodule

// File: tb/tb_usbf_sync_filter.sv
// Self-checking bench for usbf_sync_filter against a delay-line plus run-length reference model.
module tb_usbf_sync_filter;

    localparam int DW    = 4;
    localparam int STAGE = 2;
    localparam int FILT  = 4;
    localparam logic [DW-1:0] RST_VAL = 4'b0000;

    logic          clk_d;
    logic          rst;
    logic [DW-1:0] din;
    logic          filt_en;
    logic [DW-1:0] dout, rise, fall;
    logic          chg;

    int n_cmp;
    int n_fail;

    // Reference model: din samples travel through a STAGE-long delay line; a channel accepts the
    // synchronized level once it has disagreed with dout for FILT consecutive cycles.
    logic [DW-1:0] dly[$];
    logic [DW-1:0] m_dout, m_rise, m_fall;
    logic          m_chg;
    int            run_len[DW];

    usbf_sync_filter #(
        .DW     (DW),
        .STAGE  (STAGE),
        .FILT   (FILT),
        .RST_VAL(RST_VAL)
    ) dut (
        .clk_d  (clk_d),
        .rst    (rst),
        .din    (din),
        .filt_en(filt_en),
        .dout   (dout),
        .rise   (rise),
        .fall   (fall),
        .chg    (chg)
    );

    initial begin
        clk_d = 1'b0;
        forever #5 clk_d = ~clk_d;
    end

    task automatic model_reset();
        dly.delete();
        for (int k = 0; k < STAGE; k++) dly.push_back(RST_VAL);
        m_dout = RST_VAL;
        m_rise = '0;
        m_fall = '0;
        m_chg  = 1'b0;
        for (int i = 0; i < DW; i++) run_len[i] = 0;
    endtask

    // Advance model with the inputs currently applied, then clock the DUT and settle.
    task automatic tick();
        logic [DW-1:0] s_pre;
        logic [DW-1:0] prev;
        if (rst) begin
            model_reset();
        end else begin
            s_pre = dly[0];
            void'(dly.pop_front());
            dly.push_back(din);
            prev = m_dout;
            for (int i = 0; i < DW; i++) begin
                if (!filt_en) begin
                    m_dout[i] = s_pre[i];
                    run_len[i] = 0;
                end else if (s_pre[i] != m_dout[i]) begin
                    run_len[i]++;
                    if (run_len[i] >= FILT) begin
                        m_dout[i] = s_pre[i];
                        run_len[i] = 0;
                    end
                end else begin
                    run_len[i] = 0;
                end
            end
            m_rise = m_dout & ~prev;
            m_fall = ~m_dout & prev;
            m_chg  = (m_rise | m_fall) != '0;
        end
        @(posedge clk_d);
        #1;
    endtask

    task automatic test_reset();
        int lat;
        rst = 1'b1;
        din = 4'hF;
        filt_en = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if ({dout, rise, fall, chg} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %h required 0", {dout, rise, fall, chg});
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if ({dout, rise, fall, chg} !== 13'd0) begin
                n_fail++;
                $display("FAIL reset_hold c%0d: got %h required 0", c, {dout, rise, fall, chg});
            end
        end
        rst = 1'b0;
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            tick();
            n_cmp++;
            if ({dout, rise, fall, chg} !== {m_dout, m_rise, m_fall, m_chg}) begin
                n_fail++;
                $display("FAIL release c%0d: got %h required %h", c,
                         {dout, rise, fall, chg}, {m_dout, m_rise, m_fall, m_chg});
            end
            if (dout == 4'hF) begin
                lat = c;
                n_cmp++;
                if (rise !== 4'hF || fall !== 4'h0 || chg !== 1'b1) begin
                    n_fail++;
                    $display("FAIL release_pulse: got rise=%h fall=%h chg=%b required F 0 1",
                             rise, fall, chg);
                end
            end
        end
        n_cmp++;
        if (lat != STAGE + FILT) begin
            n_fail++;
            $display("FAIL release_latency: got %0d required %0d", lat, STAGE + FILT);
        end
        tick();
        n_cmp++;
        if (rise !== 4'h0 || chg !== 1'b0) begin
            n_fail++;
            $display("FAIL release_pulse_width: got rise=%h chg=%b required 0 0", rise, chg);
        end
    endtask

    task automatic test_single_rise();
        int lat;
        din = 4'h0;
        filt_en = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        n_cmp++;
        if (dout !== 4'h0) begin
            n_fail++;
            $display("FAIL settle_zero: got %h required 0", dout);
        end
        din[0] = 1'b1;
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            tick();
            n_cmp++;
            if ({dout, rise, fall, chg} !== {m_dout, m_rise, m_fall, m_chg}) begin
                n_fail++;
                $display("FAIL rise0 c%0d: got %h required %h", c,
                         {dout, rise, fall, chg}, {m_dout, m_rise, m_fall, m_chg});
            end
            if (dout[0]) begin
                lat = c;
                n_cmp++;
                if (rise !== 4'b0001 || fall !== 4'h0 || chg !== 1'b1 || dout[3:1] !== 3'b0) begin
                    n_fail++;
                    $display("FAIL rise0_pulse: got dout=%h rise=%h fall=%h chg=%b", dout, rise,
                             fall, chg);
                end
            end
        end
        n_cmp++;
        if (lat != STAGE + FILT) begin
            n_fail++;
            $display("FAIL rise0_latency: got %0d required %0d", lat, STAGE + FILT);
        end
        tick();
        n_cmp++;
        if (rise !== 4'h0 || chg !== 1'b0 || dout !== 4'b0001) begin
            n_fail++;
            $display("FAIL rise0_after: got dout=%h rise=%h chg=%b", dout, rise, chg);
        end
    endtask

    task automatic test_glitch();
        int saw_r, saw_f;
        saw_r = 0;
        saw_f = 0;
        for (int c = 0; c < 14; c++) begin
            din[1] = (c < 3);
            tick();
            n_cmp++;
            if ({dout, rise, fall, chg} !== {m_dout, m_rise, m_fall, m_chg}) begin
                n_fail++;
                $display("FAIL glitch3 c%0d: got %h required %h", c,
                         {dout, rise, fall, chg}, {m_dout, m_rise, m_fall, m_chg});
            end
            if (rise[1] || fall[1] || dout[1]) saw_r++;
        end
        n_cmp++;
        if (saw_r != 0) begin
            n_fail++;
            $display("FAIL glitch3_ignored: got %0d activity cycles required 0", saw_r);
        end
        for (int c = 0; c < 16; c++) begin
            din[1] = (c < 4);
            tick();
            n_cmp++;
            if ({dout, rise, fall, chg} !== {m_dout, m_rise, m_fall, m_chg}) begin
                n_fail++;
                $display("FAIL glitch4 c%0d: got %h required %h", c,
                         {dout, rise, fall, chg}, {m_dout, m_rise, m_fall, m_chg});
            end
            if (rise[1]) saw_r++;
            if (fall[1]) saw_f++;
        end
        n_cmp++;
        if (saw_r != 1 || saw_f != 1) begin
            n_fail++;
            $display("FAIL glitch4_pulses: got rise=%0d fall=%0d required 1 1", saw_r, saw_f);
        end
    endtask

    task automatic test_bypass();
        int lat;
        filt_en = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        din[2] = 1'b1;
        lat = 0;
        for (int c = 1; c <= 6 && lat == 0; c++) begin
            tick();
            din[2] = 1'b0;
            n_cmp++;
            if ({dout, rise, fall, chg} !== {m_dout, m_rise, m_fall, m_chg}) begin
                n_fail++;
                $display("FAIL bypass c%0d: got %h required %h", c,
                         {dout, rise, fall, chg}, {m_dout, m_rise, m_fall, m_chg});
            end
            if (dout[2] && rise[2]) lat = c;
        end
        n_cmp++;
        if (lat != STAGE + 1) begin
            n_fail++;
            $display("FAIL bypass_latency: got %0d required %0d", lat, STAGE + 1);
        end
        tick();
        n_cmp++;
        if (dout[2] !== 1'b0 || fall[2] !== 1'b1 || chg !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_fall: got dout2=%b fall2=%b chg=%b required 0 1 1", dout[2],
                     fall[2], chg);
        end
    endtask

    task automatic test_multi_channel();
        int lat;
        filt_en = 1'b1;
        din = 4'b0101;
        for (int c = 0; c < 10; c++) tick();
        n_cmp++;
        if (dout !== 4'b0101) begin
            n_fail++;
            $display("FAIL multi_setup: got %h required 5", dout);
        end
        din = 4'b1010;
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            tick();
            if (dout !== 4'b0101) lat = c;
        end
        n_cmp++;
        if (lat != STAGE + FILT || {dout, rise, fall, chg} !== {4'b1010, 4'b1010, 4'b0101, 1'b1})
        begin
            n_fail++;
            $display("FAIL multi_swap: got lat=%0d %h required lat=%0d %h", lat,
                     {dout, rise, fall, chg}, STAGE + FILT, {4'b1010, 4'b1010, 4'b0101, 1'b1});
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int c = 0; c < 400; c++) begin
            if (hold == 0) begin
                din  = DW'($urandom);
                hold = $urandom_range(1, 7);
            end
            hold--;
            if ($urandom_range(0, 19) == 0) filt_en = ~filt_en;
            tick();
            n_cmp++;
            if ({dout, rise, fall, chg} !== {m_dout, m_rise, m_fall, m_chg}) begin
                n_fail++;
                $display("FAIL random c%0d: got %h required %h", c,
                         {dout, rise, fall, chg}, {m_dout, m_rise, m_fall, m_chg});
            end
        end
    endtask

    task automatic test_reset_mid_count();
        filt_en = 1'b1;
        din = 4'hF;
        for (int c = 0; c < 10; c++) tick();
        din[0] = 1'b0;
        for (int c = 0; c < 8 && run_len[0] != 2; c++) tick();
        n_cmp++;
        if (dout !== 4'hF || run_len[0] != 2) begin
            n_fail++;
            $display("FAIL midcount_setup: got dout=%h run=%0d required F 2", dout, run_len[0]);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if ({dout, rise, fall, chg} !== 13'd0) begin
            n_fail++;
            $display("FAIL midcount_async: got %h required 0", {dout, rise, fall, chg});
        end
        tick();
        rst = 1'b0;
        filt_en = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_cmp++;
            if ({dout, rise, fall, chg} !== {m_dout, m_rise, m_fall, m_chg}) begin
                n_fail++;
                $display("FAIL post_reset c%0d: got %h required %h", c,
                         {dout, rise, fall, chg}, {m_dout, m_rise, m_fall, m_chg});
            end
            if (c == 0) begin
                n_cmp++;
                if ({rise, fall, chg} !== 9'd0) begin
                    n_fail++;
                    $display("FAIL release_no_pulse: got %h required 0", {rise, fall, chg});
                end
            end
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        rst     = 1'b1;
        din     = '0;
        filt_en = 1'b1;
        test_reset();
        test_single_rise();
        test_glitch();
        test_bypass();
        test_multi_channel();
        test_random();
        test_reset_mid_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
